reg_read_sequencer: RTL

//  Sequences operand reads through the register selector for one instruction.

---
 rtl/reg_read_sequencer.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/reg_read_sequencer.sv
// rtl/reg_read_sequencer.sv - operand read sequencer between decode and execute
// Optional HOLD-state watchdog is compiled in when SEQ_TIMEOUT_EN is defined.
module reg_read_sequencer #(
    parameter int         WIDTH    = 32,
    parameter logic [3:0] IMM_CODE = 4'h3,
    parameter int         TIMEOUT  = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             two_operand,
    input  logic [3:0]       sel1_in,
    input  logic [3:0]       sel2_in,
    input  logic [WIDTH-1:0] imm_in,
    input  logic [WIDTH-1:0] reg_data,
    output logic             clock_5,
    output logic             clock_7,
    output logic [3:0]       select_1,
    output logic [3:0]       select_2,
    output logic [WIDTH-1:0] operand_a,
    output logic [WIDTH-1:0] operand_b,
    output logic             op_valid,
    input  logic             exec_ready,
    output logic             busy,
    output logic             sel_err,
    output logic             timeout
);
    typedef enum logic [1:0] {IDLE, READ1, READ2, HOLD} state_t;

    state_t           state_q, state_d;
    logic [3:0]       sel1_q, sel1_d, sel2_q, sel2_d;
    logic             two_q, two_d;
    logic [WIDTH-1:0] imm_q, imm_d;
    logic [WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
    logic             sel_err_q, sel_err_d;
    logic             wd_expire;

    function automatic logic code_ok(input logic [3:0] code);
        return (code == IMM_CODE) || (code == 4'd1) || (code == 4'd2) || (code == 4'd4);
    endfunction

    function automatic logic [WIDTH-1:0] pick(input logic [3:0] code,
                                              input logic [WIDTH-1:0] imm,
                                              input logic [WIDTH-1:0] data);
        if (code == IMM_CODE) return imm;
        else if (code_ok(code)) return data;
        else return '0;
    endfunction

    always_comb begin
        state_d   = state_q;
        sel1_d    = sel1_q;
        sel2_d    = sel2_q;
        two_d     = two_q;
        imm_d     = imm_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        sel_err_d = sel_err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sel1_d    = sel1_in;
                    sel2_d    = sel2_in;
                    two_d     = two_operand;
                    imm_d     = imm_in;
                    op_b_d    = '0;
                    sel_err_d = 1'b0;
                    state_d   = READ1;
                end
            end
            READ1: begin
                op_a_d = pick(sel1_q, imm_q, reg_data);
                if (!code_ok(sel1_q)) sel_err_d = 1'b1;
                state_d = two_q ? READ2 : HOLD;
            end
            READ2: begin
                op_b_d = pick(sel2_q, imm_q, reg_data);
                if (!code_ok(sel2_q)) sel_err_d = 1'b1;
                state_d = HOLD;
            end
            HOLD: begin
                // a transfer on the expiry cycle takes priority over the watchdog
                if (exec_ready || wd_expire) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            sel1_q    <= '0;
            sel2_q    <= '0;
            two_q     <= 1'b0;
            imm_q     <= '0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            sel_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel1_q    <= sel1_d;
            sel2_q    <= sel2_d;
            two_q     <= two_d;
            imm_q     <= imm_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            sel_err_q <= sel_err_d;
        end
    end

    assign clock_5   = (state_q == READ1);
    assign clock_7   = (state_q == READ2);
    assign select_1  = (state_q == READ1) ? sel1_q : 4'd0;
    assign select_2  = (state_q == READ2) ? sel2_q : 4'd0;
    assign op_valid  = (state_q == HOLD);
    assign busy      = (state_q != IDLE);
    assign operand_a = op_a_q;
    assign operand_b = op_b_q;
    assign sel_err   = sel_err_q;

`ifdef SEQ_TIMEOUT_EN
    localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

    logic [7:0] wd_cnt_q, wd_cnt_d;
    logic       timeout_q, timeout_d;

    // counter reads 0 on the first HOLD cycle because it is held clear outside HOLD
    assign wd_expire = (state_q == HOLD) && !exec_ready && (wd_cnt_q == WD_LAST);
    assign wd_cnt_d  = (state_q == HOLD) ? wd_cnt_q + 8'd1 : 8'd0;
    assign timeout_d = wd_expire;

    always_ff @(posedge clock) begin
        if (reset) begin
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_cnt_q  <= wd_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign wd_expire = 1'b0;
    assign timeout   = 1'b0;
`endif
endmodule
